uart_config_show_seq: RTL and testbench
=======================================

UART_CONFIG_SHOW_SEQ -- requirements
Module: uart_config_show_seq

Interface
REQ-001 The block SHALL have parameter busWIDTH, default 8, meaning the config bus width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 The block SHALL have parameter PERIOD, default 10000, meaning the auto-report interval in clk cycles; legal range 64..2^24.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the same clock that drives uart_tx_only.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port busNow, input, [busWIDTH:1]: the config value to report.
REQ-006 The block SHALL have port showReq, input, 1 bit: one-cycle request for a single report.
REQ-007 The block SHALL have port autoEn, input, 1 bit: enables periodic reporting.
REQ-008 The block SHALL have port txBusy, input, 1 bit: busy flag from uart_tx_only.
REQ-009 The block SHALL have port txData8, output, [7:0]: character to transmit.
REQ-010 The block SHALL have port txStart, output, 1 bit: one-cycle start strobe to uart_tx_only.
REQ-011 The block SHALL have port seqBusy, output, 1 bit: high while a report is in progress.
REQ-012 The block SHALL have port seqDone, output, 1 bit: one-cycle pulse when the last character of a report has completed.

Function
REQ-013 Each report SHALL be the character sequence 'C' (0x43), '=' (0x3D), then busWIDTH/4 hex digits MSB-nibble first, then CR (0x0D) and LF (0x0A), for a total of busWIDTH/4+4 characters.
REQ-014 Hex digits SHALL be uppercase: nibble 0-9 maps to 0x30-0x39 and nibble A-F maps to 0x41-0x46.
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, SEND, ACK and DONEW.
REQ-016 IDLE->LOAD SHALL occur when a request is active: showReq, or the pending flag, or an auto tick.
REQ-017 In LOAD, busNow SHALL be captured into a snapshot register and the character index cleared; LOAD->SEND SHALL follow in the next cycle.
REQ-018 SEND SHALL wait while txBusy=1; when txBusy=0 it SHALL drive txData8=char[index] and txStart=1 for exactly one cycle, then go to ACK.
REQ-019 ACK SHALL wait for txBusy=1, then go to DONEW.
REQ-020 If txBusy has not risen within 4 cycles of txStart, ACK SHALL go to DONEW anyway (lost-start guard).
REQ-021 DONEW SHALL wait for txBusy=0, then increment the index. If that was the last character, it SHALL pulse seqDone for 1 cycle and return to IDLE; otherwise it SHALL go to SEND.
REQ-022 txData8 SHALL hold its value from the txStart cycle until the next txStart.
REQ-023 Report content SHALL come only from the snapshot; changes on busNow during a report SHALL NOT affect it.
REQ-024 A showReq or auto tick arriving while seqBusy=1 SHALL set a single pending flag (further requests merge into it). The pending flag SHALL be cleared on entry to LOAD.
REQ-025 A request in the same cycle as seqDone SHALL be captured as pending, and the next report SHALL start from IDLE in the following cycle.
REQ-026 The auto timer SHALL count 0..PERIOD-1 while autoEn=1 and wrap. The tick SHALL occur on the PERIOD-1 count.
REQ-027 With autoEn=0 the timer SHALL be held at 0 and no ticks SHALL occur.
REQ-028 The timer SHALL keep running during reports.
REQ-029 seqBusy SHALL be 1 in every state except IDLE.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE; txStart, seqBusy, seqDone, the pending flag, the index and the timer SHALL all be 0; txData8 SHALL be 0x00; the snapshot SHALL be 0.
REQ-031 Assertion of rst mid-report SHALL abort the report immediately with no further txStart.
REQ-032 After rst is released, the block SHALL start no report until a new request arrives.

Verification
REQ-033 Scenario: busWIDTH=8, busNow=0xA5, showReq pulse, with a tx model that raises txBusy 1 cycle after txStart for 10 cycles. Required response: txData8 at successive txStart strobes is 0x43, 0x3D, 0x41, 0x35, 0x0D, 0x0A; exactly 6 txStart strobes; then 1 seqDone pulse.
REQ-034 Scenario: busNow is changed from 0xA5 to 0x3C after the second character. Required response: the report still sends 0x41, 0x35; the next report sends 0x33, 0x43.
REQ-035 Scenario: showReq is pulsed 3 times during a report. Required response: exactly one further report follows, starting 1 cycle after seqDone.
REQ-036 Scenario: autoEn=1 with PERIOD=200 and an idle tx. Required response: reports start at cycles 200, 400, ... after enable; with autoEn=0 there are no reports.
REQ-037 Scenario: rst is asserted after the third txStart. Required response: outputs are 0 at once, no further txStart occurs, and showReq after release gives a full 6-character report.
REQ-038 Scenario: txBusy is held at 0 (tx model ignores txStart). Required response: each character advances after the 4-cycle guard, and seqDone is still pulsed after 6 strobes.

Source files
------------

// File: rtl/uart_config_show_seq.sv
// uart_config_show_seq: formats a config bus value as "C=<hex>\r\n" and feeds
// it character by character to a uart_tx_only transmitter. Reports start on
// a one-cycle request or on a periodic auto tick. Requests that arrive while
// a report is running merge into a single pending report.
module uart_config_show_seq #(
  parameter int busWIDTH = 8,
  parameter int PERIOD   = 10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [busWIDTH:1]   busNow,
  input  logic                showReq,
  input  logic                autoEn,
  input  logic                txBusy,
  output logic [7:0]          txData8,
  output logic                txStart,
  output logic                seqBusy,
  output logic                seqDone
);

  localparam int NDIG   = busWIDTH / 4;
  localparam int NCHARS = NDIG + 4;
  localparam int IW     = $clog2(NCHARS);
  localparam int TW     = $clog2(PERIOD);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NCHARS - 1);
  localparam logic [TW-1:0] TIMER_TOP = TW'(PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    ACK,
    DONEW
  } state_t;

  state_t              state;
  logic [busWIDTH-1:0] snap;
  logic [IW-1:0]       idx;
  logic [1:0]          guard;
  logic                pending;
  logic [TW-1:0]       timer;
  logic                tick;
  logic                req;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Character at position i of the report built from snapshot v.
  function automatic logic [7:0] char_at(input logic [IW-1:0] i,
                                         input logic [busWIDTH-1:0] v);
    logic [7:0]          c;
    logic [busWIDTH-1:0] sh;
    int                  k;
    k  = int'(i) - 2;
    sh = '0;
    if (i == '0)                 c = 8'h43;
    else if (i == IW'(1))        c = 8'h3D;
    else if (i == LAST_IDX)      c = 8'h0A;
    else if (i == LAST_IDX - 1'b1) c = 8'h0D;
    else begin
      // Digit k (0 = most significant nibble) shifted down to bits [3:0].
      sh = v >> (4 * (NDIG - 1 - k));
      c  = hex_char(sh[3:0]);
    end
    return c;
  endfunction

  // Auto tick fires on the last count of the period; any request source.
  always_comb begin
    tick = autoEn && (timer == TIMER_TOP);
    req  = showReq || tick;
  end

  // Free-running report interval timer, held at zero while auto mode is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         timer <= '0;
    else if (!autoEn) timer <= '0;
    else if (tick)    timer <= '0;
    else              timer <= timer + 1'b1;
  end

  // Report sequencer: snapshot, per-character start/ack handshake, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      idx     <= '0;
      guard   <= '0;
      pending <= 1'b0;
      txData8 <= 8'h00;
      txStart <= 1'b0;
      seqBusy <= 1'b0;
      seqDone <= 1'b0;
    end else begin
      txStart <= 1'b0;
      seqDone <= 1'b0;
      // Requests seen while a report runs collapse into one pending report.
      if (state != IDLE && req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (showReq || pending || tick) begin
            state   <= LOAD;
            seqBusy <= 1'b1;
            pending <= 1'b0;
          end
        end
        LOAD: begin
          snap  <= busNow;
          idx   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (!txBusy) begin
            txData8 <= char_at(idx, snap);
            txStart <= 1'b1;
            guard   <= '0;
            state   <= ACK;
          end
        end
        ACK: begin
          // Give the transmitter four cycles to acknowledge; a lost start
          // must not stall the report forever.
          if (txBusy || guard == 2'd3) state <= DONEW;
          else                         guard <= guard + 1'b1;
        end
        DONEW: begin
          if (!txBusy) begin
            if (idx == LAST_IDX) begin
              idx     <= '0;
              seqDone <= 1'b1;
              seqBusy <= 1'b0;
              state   <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SEND;
            end
          end
        end
        default: begin
          state   <= IDLE;
          seqBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_config_show_seq.sv
// Directed bench for uart_config_show_seq with a small uart_tx_only model.
module tb_uart_config_show_seq;

  logic       clk;
  logic       rst;
  logic [8:1] busNow;
  logic       showReq;
  logic       autoEn;
  logic       txBusy;
  logic [7:0] txData8;
  logic       txStart;
  logic       seqBusy;
  logic       seqDone;

  int checks;
  int errors;
  int cyc;

  logic [7:0] chars[$];
  int         scyc[$];
  int         starts[$];
  int         done_cnt;
  int         done_cyc;
  logic       prev_busy;

  logic       ignore;
  logic       bpend;
  int         bcnt;

  uart_config_show_seq #(.busWIDTH(8), .PERIOD(200)) dut (
    .clk     (clk),
    .rst     (rst),
    .busNow  (busNow),
    .showReq (showReq),
    .autoEn  (autoEn),
    .txBusy  (txBusy),
    .txData8 (txData8),
    .txStart (txStart),
    .seqBusy (seqBusy),
    .seqDone (seqDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy goes high one cycle after txStart for 10 cycles.
  always @(negedge clk) begin
    if (rst) begin
      txBusy = 1'b0;
      bcnt   = 0;
      bpend  = 1'b0;
    end else begin
      if (bpend) begin
        txBusy = 1'b1;
        bcnt   = 10;
        bpend  = 1'b0;
      end else if (bcnt > 0) begin
        bcnt = bcnt - 1;
        if (bcnt == 0) txBusy = 1'b0;
      end
      if (txStart && !ignore) bpend = 1'b1;
    end
  end

  // Output recorder.
  always @(negedge clk) begin
    if (txStart) begin
      chars.push_back(txData8);
      scyc.push_back(cyc);
    end
    if (seqDone) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (seqBusy && !prev_busy) starts.push_back(cyc);
    prev_busy = seqBusy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_show();
    showReq = 1'b1;
    tick();
    showReq = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    for (int k = 0; k < 2000 && chars.size() < n; k++) tick();
    if (chars.size() < n) check(tag, chars.size(), n);
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int k = 0; k < 2000 && done_cnt < n; k++) tick();
    if (done_cnt < n) check(tag, done_cnt, n);
  endtask

  task automatic check_report(input string tag, input int base, input logic [7:0] d_hi,
                              input logic [7:0] d_lo);
    logic [7:0] exp[6];
    exp[0] = 8'h43; exp[1] = 8'h3D; exp[2] = d_hi;
    exp[3] = d_lo;  exp[4] = 8'h0D; exp[5] = 8'h0A;
    for (int i = 0; i < 6; i++) begin
      if (base + i < chars.size()) check($sformatf("%s_c%0d", tag, i), chars[base + i], exp[i]);
      else check($sformatf("%s_c%0d_missing", tag, i), chars.size(), base + i + 1);
    end
  endtask

  initial begin
    int c0;
    int n0;
    int gap;
    checks = 0; errors = 0; cyc = 0;
    done_cnt = 0; done_cyc = 0; prev_busy = 1'b0;
    ignore = 1'b0; bpend = 1'b0; bcnt = 0; txBusy = 1'b0;
    rst = 1'b1; busNow = 8'hA5; showReq = 1'b0; autoEn = 1'b0;
    repeat (3) tick();
    check("rst_txData8", txData8, 8'h00);
    check("rst_txStart", txStart, 1'b0);
    check("rst_seqBusy", seqBusy, 1'b0);
    check("rst_seqDone", seqDone, 1'b0);
    rst = 1'b0;
    repeat (20) tick();
    check("idle_no_report", starts.size(), 0);

    // Basic report of 0xA5.
    pulse_show();
    wait_done(1, "s1_done_timeout");
    repeat (30) tick();
    check("s1_strobes", chars.size(), 6);
    check_report("s1", 0, 8'h41, 8'h35);
    check("s1_done_pulses", done_cnt, 1);

    // Bus changes mid-report; next report picks up the new value.
    chars.delete();
    pulse_show();
    wait_strobes(2, "s2_strobe_timeout");
    busNow = 8'h3C;
    wait_done(2, "s2_done_timeout");
    check_report("s2a", 0, 8'h41, 8'h35);
    pulse_show();
    wait_done(3, "s2b_done_timeout");
    check_report("s2b", 6, 8'h33, 8'h43);

    // Three requests during a report merge into one follow-up report.
    chars.delete(); starts.delete();
    pulse_show();
    wait_strobes(1, "s3_strobe_timeout");
    pulse_show(); repeat (3) tick();
    pulse_show(); repeat (5) tick();
    pulse_show();
    wait_done(4, "s3_done_timeout");
    c0 = done_cyc;
    tick();
    check("s3_followup_busy", seqBusy, 1'b1);
    wait_done(5, "s3_done2_timeout");
    repeat (100) tick();
    check("s3_reports", starts.size(), 2);
    if (starts.size() >= 2) check("s3_followup_start", starts[1] - c0, 1);
    check("s3_strobes", chars.size(), 12);

    // Periodic reports every 200 cycles after enable.
    chars.delete(); starts.delete();
    autoEn = 1'b1;
    c0 = cyc;
    wait_done(8, "s4_done_timeout");
    check("s4_reports", starts.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < starts.size()) check($sformatf("s4_start%0d", i), starts[i] - c0, 200 * (i + 1));
    autoEn = 1'b0;
    repeat (500) tick();
    check("s4_off_reports", starts.size(), 3);

    // Reset in the middle of a report.
    chars.delete();
    pulse_show();
    wait_strobes(3, "s5_strobe_timeout");
    rst = 1'b1;
    #1;
    check("s5_abort_txStart", txStart, 1'b0);
    check("s5_abort_seqBusy", seqBusy, 1'b0);
    check("s5_abort_txData8", txData8, 8'h00);
    n0 = chars.size();
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();
    check("s5_no_more_start", chars.size(), n0);
    check("s5_idle_after", seqBusy, 1'b0);
    chars.delete();
    pulse_show();
    wait_done(9, "s5_done_timeout");
    repeat (20) tick();
    check("s5_strobes", chars.size(), 6);
    check_report("s5", 0, 8'h33, 8'h43);

    // Transmitter never acknowledges: guard timeout advances each character.
    chars.delete(); scyc.delete();
    ignore = 1'b1;
    pulse_show();
    wait_done(10, "s6_done_timeout");
    repeat (20) tick();
    check("s6_strobes", chars.size(), 6);
    check_report("s6", 0, 8'h33, 8'h43);
    if (scyc.size() >= 2) begin
      gap = scyc[1] - scyc[0];
      check("s6_gap_ge5", (gap >= 5) ? 1 : 0, 1);
      check("s6_gap_le7", (gap <= 7) ? 1 : 0, 1);
    end
    check("s6_done_pulses", done_cnt, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
